rs_latch_driver: RTL and testbench



---
 rtl/rs_latch_driver.sv | 150 +++++++++++++++
 tb/tb_rs_latch_driver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_latch_driver.sv
// rs_latch_driver: conditions two raw push buttons into timed, mutually
// exclusive S/R pulses for a NOR SR latch and verifies the latch switched.
module rs_latch_driver #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  input  logic q_fb,
  input  logic qb_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {IDLE, PULSE, CHECK, GAP} state_t;
  typedef enum logic {KIND_S, KIND_R} kind_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  // Channel 0 is the set button, channel 1 the reset button.
  logic [1:0]       btn;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       deb_prev;
  logic [1:0]       rise;
  logic [1:0]       pend;
  logic [1:0]       clr;
  logic [CNT_W-1:0] deb_cnt [2];

  state_t           state, state_nx;
  kind_t            kind, kind_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             err_q;
  logic             err_set;
  logic             match;

  assign btn  = {rst_btn, set_btn};
  assign rise = deb & ~deb_prev;

  // Synchronise each button and debounce it: deb follows sync only after
  // DEB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // FSM state, sticky error and pending-request registers; a new rising
  // edge wins over the clear so a request arriving during dispatch is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      kind  <= KIND_S;
      cnt   <= '0;
      err_q <= 1'b0;
      pend  <= '0;
    end else begin
      state <= state_nx;
      kind  <= kind_nx;
      cnt   <= cnt_nx;
      err_q <= err_q | err_set;
      pend  <= (pend & ~clr) | rise;
    end
  end

  // Next-state and output decode; R requests take priority over S.
  always_comb begin
    state_nx = state;
    kind_nx  = kind;
    cnt_nx   = cnt;
    clr      = '0;
    s        = 1'b0;
    r        = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    err_set  = 1'b0;
    match    = 1'b0;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        cnt_nx = '0;
        if (pend[1]) begin
          state_nx = PULSE;
          kind_nx  = KIND_R;
          clr[1]   = 1'b1;
        end else if (pend[0]) begin
          state_nx = PULSE;
          kind_nx  = KIND_S;
          clr[0]   = 1'b1;
        end
      end
      PULSE: begin
        s = (kind == KIND_S);
        r = (kind == KIND_R);
        if (cnt == PULSE_LAST) begin
          cnt_nx   = '0;
          state_nx = CHECK;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      CHECK: begin
        match = (kind == KIND_R) ? (!q_fb && qb_fb) : (q_fb && !qb_fb);
        if (match) done = 1'b1;
        else       err_set = 1'b1;
        cnt_nx   = '0;
        state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    err = err_q | err_set;
  end

endmodule

// File: tb/tb_rs_latch_driver.sv
// tb_rs_latch_driver: drives two driver instances (default and minimum
// timing) with shared buttons, models each latch, and compares every cycle
// against a timeline-based reference model.
module tb_rs_latch_driver;

  localparam int HN = 8192;

  logic clk = 1'b0;
  logic rst_n, set_btn, rst_btn;
  logic [1:0] qv, qbv;
  logic s0, r0, busy0, done0, err0;
  logic s1, r1, busy1, done1, err1;
  logic [1:0] s_v, r_v, busy_v, done_v, err_v;

  assign s_v    = {s1, s0};
  assign r_v    = {r1, r0};
  assign busy_v = {busy1, busy0};
  assign done_v = {done1, done0};
  assign err_v  = {err1, err0};

  rs_latch_driver #(.DEB_CYCLES(4), .PULSE_CYCLES(2), .GAP_CYCLES(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
    .q_fb(qv[0]), .qb_fb(qbv[0]), .s(s0), .r(r0), .busy(busy0), .done(done0), .err(err0));

  rs_latch_driver #(.DEB_CYCLES(1), .PULSE_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
    .q_fb(qv[1]), .qb_fb(qbv[1]), .s(s1), .r(r1), .busy(busy1), .done(done1), .err(err1));

  always #5 clk = ~clk;

  function automatic int pd(int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int pp(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int pg(int i); return (i == 0) ? 1 : 0; endfunction

  int checks = 0;
  int passes = 0;

  // raw button history indexed by edge number, zeroed around reset edges
  bit hs [HN];
  bit hr [HN];
  int n = 8;
  bit stuck = 1'b0;

  // reference model state per instance
  bit mdeb_s [2], mdeb_r [2], rose_s [2], rose_r [2];
  bit mps [2], mpr [2], mact [2], mkind [2], msticky [2], mq [2];
  int mt0 [2];
  bit es [2], er [2], ebusy [2], edone [2], eerr [2];

  // observation statistics
  int first_s [2], first_r [2], s_hi [2], r_hi [2], done_cnt [2], busy_cnt [2];
  int t_press;

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      first_s[i] = -1; first_r[i] = -1; s_hi[i] = 0; r_hi[i] = 0;
      done_cnt[i] = 0; busy_cnt[i] = 0;
    end
  endtask

  // deb flips at edge nn once the last D synchronised samples all disagree
  function automatic bit all_differ(bit is_r, int nn, int d, bit cur);
    for (int k = 0; k < d; k++) begin
      if ((is_r ? hr[nn-2-k] : hs[nn-2-k]) == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    int off, p, g, d;
    bit idle_pre, flip, chk_cyc;
    n++;
    if (!rst_n) begin
      hs[n] = 1'b0; hr[n] = 1'b0; hs[n-1] = 1'b0; hr[n-1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mdeb_s[i] = 0; mdeb_r[i] = 0; rose_s[i] = 0; rose_r[i] = 0;
        mps[i] = 0; mpr[i] = 0; mact[i] = 0; msticky[i] = 0;
        es[i] = 0; er[i] = 0; ebusy[i] = 0; edone[i] = 0; eerr[i] = 0;
        if (stuck) mq[i] = 1'b0;
      end
    end else begin
      hs[n] = set_btn; hr[n] = rst_btn;
      for (int i = 0; i < 2; i++) begin
        p = pp(i); g = pg(i); d = pd(i);
        idle_pre = !mact[i] || ((n - 1 - mt0[i]) >= p + g + 1);
        if (idle_pre) begin
          mact[i] = 1'b0;
          if (mpr[i] || mps[i]) begin
            mact[i] = 1'b1; mt0[i] = n; mkind[i] = mpr[i];
            if (mpr[i]) mpr[i] = 1'b0; else mps[i] = 1'b0;
          end
        end
        if (rose_s[i]) mps[i] = 1'b1;
        if (rose_r[i]) mpr[i] = 1'b1;
        flip = all_differ(1'b0, n, d, mdeb_s[i]);
        rose_s[i] = flip && !mdeb_s[i];
        if (flip) mdeb_s[i] = !mdeb_s[i];
        flip = all_differ(1'b1, n, d, mdeb_r[i]);
        rose_r[i] = flip && !mdeb_r[i];
        if (flip) mdeb_r[i] = !mdeb_r[i];
        es[i] = 0; er[i] = 0; ebusy[i] = 0; chk_cyc = 0;
        if (mact[i]) begin
          off = n - mt0[i];
          es[i]    = !mkind[i] && off < p;
          er[i]    =  mkind[i] && off < p;
          ebusy[i] = off <= p + g;
          chk_cyc  = off == p;
        end
        if (stuck) mq[i] = 1'b0;
        else if (es[i]) mq[i] = 1'b1;
        else if (er[i]) mq[i] = 1'b0;
        edone[i] = chk_cyc && (mkind[i] ? (mq[i] == 1'b0) : (mq[i] == 1'b1));
        if (chk_cyc && !edone[i]) msticky[i] = 1'b1;
        eerr[i] = msticky[i];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    for (int i = 0; i < 2; i++) begin
      if (stuck)       begin qv[i] = 1'b0; qbv[i] = 1'b1; end
      else if (s_v[i]) begin qv[i] = 1'b1; qbv[i] = 1'b0; end
      else if (r_v[i]) begin qv[i] = 1'b0; qbv[i] = 1'b1; end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("n%0d inst%0d s", n, i), s_v[i], es[i]);
      chk($sformatf("n%0d inst%0d r", n, i), r_v[i], er[i]);
      chk($sformatf("n%0d inst%0d busy", n, i), busy_v[i], ebusy[i]);
      chk($sformatf("n%0d inst%0d done", n, i), done_v[i], edone[i]);
      chk($sformatf("n%0d inst%0d err", n, i), err_v[i], eerr[i]);
      chk($sformatf("n%0d inst%0d s_and_r", n, i), s_v[i] & r_v[i], 1'b0);
      if (s_v[i]) begin s_hi[i]++; if (first_s[i] < 0) first_s[i] = n; end
      if (r_v[i]) begin r_hi[i]++; if (first_r[i] < 0) first_r[i] = n; end
      if (done_v[i]) done_cnt[i]++;
      if (busy_v[i]) busy_cnt[i]++;
    end
  endtask

  task automatic run(int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    int hold;
    bit seen;
    rst_n = 1'b0; set_btn = 1'b0; rst_btn = 1'b0;
    qv = 2'b00; qbv = 2'b11;
    for (int i = 0; i < 2; i++) begin mq[i] = 1'b0; mt0[i] = 0; end
    clear_stats();

    // reset, then a clean set press
    run(2);
    rst_n = 1'b1;
    run(3);
    chk("reset s0", s0, 1'b0);
    chk("reset busy0", busy0, 1'b0);
    chk("reset err1", err1, 1'b0);
    clear_stats();
    set_btn = 1'b1; t_press = n + 1;
    run(20);
    chk_int("set latency inst0", first_s[0] - t_press, 7);
    chk_int("set latency inst1", first_s[1] - t_press, 4);
    chk_int("set width inst0", s_hi[0], 2);
    chk_int("set width inst1", s_hi[1], 1);
    chk_int("set done inst0", done_cnt[0], 1);
    chk_int("set r inst0", r_hi[0], 0);
    set_btn = 1'b0;
    run(15);

    // bounce rejection on the default instance
    clear_stats();
    for (int k = 0; k < 20; k++) begin
      set_btn = ((k / 2) % 2) == 0;
      step();
    end
    set_btn = 1'b0;
    run(20);
    chk_int("bounce s inst0", s_hi[0], 0);
    chk_int("bounce busy inst0", busy_cnt[0], 0);

    // simultaneous requests: R first, then S
    clear_stats();
    set_btn = 1'b1; rst_btn = 1'b1; t_press = n + 1;
    run(25);
    chk_int("simul r start inst0", first_r[0] - t_press, 7);
    chk_int("simul s start inst0", first_s[0] - t_press, 12);
    chk_int("simul done inst0", done_cnt[0], 2);
    chk_int("simul done inst1", done_cnt[1], 2);
    set_btn = 1'b0; rst_btn = 1'b0;
    run(15);

    // verification failure with a stuck latch; err stays sticky
    clear_stats();
    stuck = 1'b1;
    step();
    set_btn = 1'b1;
    run(20);
    chk("stuck err0", err0, 1'b1);
    chk("stuck err1", err1, 1'b1);
    set_btn = 1'b0;
    run(10);
    stuck = 1'b0;
    rst_btn = 1'b1;
    run(20);
    rst_btn = 1'b0;
    run(10);
    chk("sticky err0", err0, 1'b1);
    chk_int("sticky done inst0", done_cnt[0], 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("err cleared err0", err0, 1'b0);
    run(5);

    // reset during the second pulse cycle with a reset request pending
    clear_stats();
    set_btn = 1'b1;
    step();
    rst_btn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step();
      seen = s0;
    end
    chk("midop s0 seen", seen, 1'b1);
    step();
    chk("midop second pulse s0", s0, 1'b1);
    rst_n = 1'b0; set_btn = 1'b0; rst_btn = 1'b0;
    step();
    chk("midop abort s0", s0, 1'b0);
    chk("midop abort busy0", busy0, 1'b0);
    rst_n = 1'b1;
    clear_stats();
    run(30);
    chk_int("midop s after inst0", s_hi[0], 0);
    chk_int("midop r after inst0", r_hi[0], 0);
    chk_int("midop r after inst1", r_hi[1], 0);

    // back-to-back requests on the minimum-timing instance
    clear_stats();
    for (int k = 0; k < 40; k++) begin
      set_btn = (k % 4) < 2;
      step();
    end
    set_btn = 1'b0;
    run(15);
    chk_int("b2b done inst1", done_cnt[1], 10);
    chk_int("b2b busy inst1", busy_cnt[1], 20);
    chk_int("b2b done inst0", done_cnt[0], 0);

    // randomized button activity, occasional stuck latch and resets
    for (int seg = 0; seg < 300; seg++) begin
      set_btn = $urandom_range(0, 1);
      rst_btn = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) stuck = ~stuck;
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      hold = $urandom_range(1, 10);
      run(hold);
    end
    stuck = 1'b0; set_btn = 1'b0; rst_btn = 1'b0;
    run(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
